// File: rtl/dcmi_rx.sv
// dcmi_rx: captures one DCMI camera frame into an on-chip byte buffer and
// lets a CPU read port drain it a byte at a time.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   nRST       asynchronous active-low reset
//   DCLK       external pixel clock (asynchronous, at most CLK/4)
//   DSYNC      external frame-valid, active-high
//   DATA[7:0]  external pixel data, stable around the DCLK rising edge
//   ARM        one-CLK pulse: clear the buffer and arm capture of the next frame
//   RD         one-CLK pulse: pop the head byte (only acted on in DONE)
//   DO[7:0]    registered head-of-buffer byte, IDLE_BYTE when nothing to read
//   BUSY       high in ARMED and CAPTURE
//   READY      high in DONE while the buffer holds data
//   OVF        sticky: a byte was dropped because the buffer was full
//   LEN        number of bytes currently held
//   dbg_state  current FSM state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
//
// Handshake: ARM and RD are single-cycle strobes with no back-pressure. An RD
// strobe in DONE with LEN>0 pops exactly one byte and the new head appears on
// DO after that same clock edge; RD is ignored in any other situation. ARM
// wins over a simultaneous RD or capture write.

module dcmi_rx #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  DCLK,
  input  logic                  DSYNC,
  input  logic [7:0]            DATA,
  input  logic                  ARM,
  input  logic                  RD,
  output logic [7:0]            DO,
  output logic                  BUSY,
  output logic                  READY,
  output logic                  OVF,
  output logic [DEPTH_LOG2:0]   LEN,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_n;

  // Bit 0/1 are the two synchronizer flops; bit 2 is the edge-detect history.
  logic [2:0] dclk_sr;
  logic [2:0] sync_sr;
  logic [7:0] data_s1, data_s2;

  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_n;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_n;
  logic [DEPTH_LOG2:0]   len, len_n;
  logic                  ovf, ovf_n;
  logic                  seen_low, seen_low_n;
  logic                  wr_en;

  logic [7:0] mem [DEPTH];

  logic dclk_rise;
  logic sync_hi;
  logic sync_fall;

  assign dclk_rise = dclk_sr[1] & ~dclk_sr[2];
  assign sync_hi   = sync_sr[1];
  assign sync_fall = sync_sr[2] & ~sync_sr[1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dclk_sr <= 3'b000;
      sync_sr <= 3'b000;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      dclk_sr <= {dclk_sr[1:0], DCLK};
      sync_sr <= {sync_sr[1:0], DSYNC};
      data_s1 <= DATA;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      len      <= '0;
      ovf      <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      len      <= len_n;
      ovf      <= ovf_n;
      seen_low <= seen_low_n;
    end
  end

  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    len_n      = len;
    ovf_n      = ovf;
    seen_low_n = seen_low;
    wr_en      = 1'b0;
    if (ARM) begin
      state_n    = S_ARMED;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      len_n      = '0;
      ovf_n      = 1'b0;
      seen_low_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ARMED: begin
          // Require a low before accepting a rise so that a frame already in
          // flight when ARM arrived is skipped entirely.
          if (!sync_hi) seen_low_n = 1'b1;
          else if (seen_low) state_n = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (sync_fall) begin
            state_n = S_DONE;
          end else if (dclk_rise && sync_hi) begin
            if (len == FULL_LEN) begin
              ovf_n = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
              len_n    = len + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (RD && (len != '0)) begin
            rd_ptr_n = rd_ptr + 1'b1;
            len_n    = len - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Buffer storage carries no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= data_s2;
  end

  // Read address is the next-cycle pointer so DO already shows the new head
  // on the edge that applies a pop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DO <= IDLE_BYTE;
    end else if ((state_n == S_DONE) && (len_n != '0)) begin
      DO <= mem[rd_ptr_n];
    end else begin
      DO <= IDLE_BYTE;
    end
  end

  assign BUSY      = (state == S_ARMED) || (state == S_CAPTURE);
  assign READY     = (state == S_DONE) && (len != '0);
  assign OVF       = ovf;
  assign LEN       = len;
  assign dbg_state = state;

endmodule

// File: tb/tb_dcmi_rx.sv
// tb_dcmi_rx: directed bench for dcmi_rx with a frame-level reference model
// (byte queue plus capture mode) checked every cycle, plus literal checks.

module tb_dcmi_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dclk = 1'b0;
  logic       dsync = 1'b0;
  logic [7:0] data = 8'h00;
  logic       arm = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] do_q;
  logic       busy, ready, ovf;
  logic [8:0] len;
  logic [1:0] dbg_state;

  dcmi_rx #(.DEPTH_LOG2(8), .IDLE_BYTE(8'h00)) dut (
    .CLK(clk), .nRST(rst_n), .DCLK(dclk), .DSYNC(dsync), .DATA(data),
    .ARM(arm), .RD(rd), .DO(do_q), .BUSY(busy), .READY(ready), .OVF(ovf),
    .LEN(len), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference model
  typedef enum {M_IDLE, M_ARMW, M_ARMR, M_CAP, M_DONE} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare on the falling edge, away from the active edge
  logic [7:0] m_do;
  bit         m_ready;
  always @(negedge clk) begin
    if (chk_en) begin
      m_ready = (m_mode == M_DONE) && (exp_q.size() > 0);
      m_do    = 8'h00;
      if (m_ready) m_do = exp_q[0];
      check("cmp_len",   32'(len), 32'(exp_q.size()));
      check("cmp_do",    32'(do_q), 32'(m_do));
      check("cmp_ready", 32'(ready), 32'(m_ready));
      check("cmp_busy",  32'(busy),
            32'((m_mode == M_ARMW) || (m_mode == M_ARMR) || (m_mode == M_CAP)));
      check("cmp_ovf",   32'(ovf), 32'(m_ovf));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_arm();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_mode = dsync ? M_ARMW : M_ARMR;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    model_arm();
  endtask

  task automatic arm_rd_pulse();
    arm = 1'b1;
    rd  = 1'b1;
    tick(1);
    arm = 1'b0;
    rd  = 1'b0;
    model_arm();
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if ((m_mode == M_DONE) && (exp_q.size() > 0)) void'(exp_q.pop_front());
  endtask

  task automatic set_dsync(input logic v);
    chk_en = 1'b0;
    dsync = v;
    tick(4);
    if (v) begin
      if (m_mode == M_ARMR) m_mode = M_CAP;
    end else begin
      if (m_mode == M_CAP) m_mode = M_DONE;
      else if (m_mode == M_ARMW) m_mode = M_ARMR;
    end
    chk_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk_en = 1'b0;
    data = b;
    tick(2);
    dclk = 1'b1;
    tick(2);
    dclk = 1'b0;
    tick(2);
    if ((m_mode == M_CAP) && dsync) begin
      if (exp_q.size() < 256) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  // stimulus
  logic [7:0] vec4 [4];
  logic [7:0] b;

  initial begin
    vec4[0] = 8'h11; vec4[1] = 8'h22; vec4[2] = 8'h33; vec4[3] = 8'h44;

    // reset state
    tick(3);
    check("rst_do",   32'(do_q), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_len",  32'(len),  32'h0);
    check("rst_ready",32'(ready),32'h0);
    check("rst_ovf",  32'(ovf),  32'h0);
    rst_n = 1'b1;
    tick(1);
    chk_en = 1'b1;

    // basic 4-byte frame
    arm_pulse();
    check("arm_busy", 32'(busy), 32'h1);
    set_dsync(1'b1);
    for (int i = 0; i < 4; i++) send_byte(vec4[i]);
    set_dsync(1'b0);
    check("f4_len",   32'(len),   32'h4);
    check("f4_ready", 32'(ready), 32'h1);
    check("f4_busy",  32'(busy),  32'h0);
    for (int i = 0; i < 4; i++) begin
      check("f4_do", 32'(do_q), 32'(vec4[i]));
      rd_pulse();
    end
    check("f4_len_end",   32'(len),   32'h0);
    check("f4_ready_end", 32'(ready), 32'h0);
    check("f4_do_end",    32'(do_q),  32'h00);
    rd_pulse();
    tick(2);
    check("empty_rd_len", 32'(len), 32'h0);

    // ARM mid-frame: remainder skipped, next frame captured; RD during capture ignored
    set_dsync(1'b1);
    send_byte(8'h51);
    send_byte(8'h52);
    arm_pulse();
    send_byte(8'h53);
    send_byte(8'h54);
    set_dsync(1'b0);
    check("skip_len", 32'(len), 32'h0);
    set_dsync(1'b1);
    send_byte(8'hAA);
    rd_pulse();
    send_byte(8'hBB);
    rd_pulse();
    rd_pulse();
    check("cap_rd_len", 32'(len), 32'h2);
    send_byte(8'hCC);
    set_dsync(1'b0);
    check("f3_len", 32'(len), 32'h3);
    check("f3_do",  32'(do_q), 32'hAA);
    repeat (3) rd_pulse();

    // overflow: 300-byte frame, full readout
    arm_pulse();
    set_dsync(1'b1);
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    set_dsync(1'b0);
    check("ovf_len", 32'(len), 32'h100);
    check("ovf_flag", 32'(ovf), 32'h1);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      check("ovf_rd_do", 32'(do_q), 32'(b));
      rd_pulse();
    end
    check("ovf_len_end", 32'(len), 32'h0);
    check("ovf_sticky",  32'(ovf), 32'h1);

    // ARM and RD together with LEN=2 in DONE
    arm_pulse();
    set_dsync(1'b1);
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    set_dsync(1'b0);
    repeat (254) rd_pulse();
    check("pre_arm_len", 32'(len),  32'h2);
    check("pre_arm_do",  32'(do_q), 32'hFE);
    check("pre_arm_ovf", 32'(ovf),  32'h1);
    arm_rd_pulse();
    check("armrd_busy", 32'(busy), 32'h1);
    check("armrd_len",  32'(len),  32'h0);
    check("armrd_ovf",  32'(ovf),  32'h0);
    check("armrd_do",   32'(do_q), 32'h00);

    // reset mid-capture, then a frame without ARM
    set_dsync(1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i));
    check("pre_rst_len", 32'(len), 32'hA);
    chk_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_mode = M_IDLE;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_len",  32'(len),  32'h0);
    check("mid_rst_do",   32'(do_q), 32'h00);
    tick(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'h90);
    set_dsync(1'b0);
    set_dsync(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i));
    set_dsync(1'b0);
    check("noarm_len",  32'(len),  32'h0);
    check("noarm_busy", 32'(busy), 32'h0);
    tick(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
